// File: rtl/mem_arbiter.sv
// Two-requester (fetch I, load/store D) arbiter and one-outstanding sequencer for a memory channel.
// Define MEM_ARB_STARVE_GUARD_EN to let a starving fetch through after STARVE_LIMIT D grants.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_kill,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic [1:0]  rw_flag,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    output logic [3:0]  write_mask,
    input  logic [31:0] read_data,
    input  logic        busy,
    input  logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic        own_i_q, own_i_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        kill_q, kill_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant_i, grant_d;
    logic        i_ok;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0]  starve_cnt_q, starve_cnt_d;
`else
    logic        unused_limit;
    assign unused_limit = ^LIMIT;
`endif

    assign i_ok = i_req && !i_kill;

    always_comb begin
        state_d   = state_q;
        own_i_d   = own_i_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        kill_d    = kill_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        starve_cnt_d = starve_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef MEM_ARB_STARVE_GUARD_EN
                if (i_ok && d_req) grant_i = (starve_cnt_q == LIMIT);
                else               grant_i = i_ok;
                grant_d = d_req && !grant_i;
`else
                grant_d = d_req;
                grant_i = i_ok && !d_req;
`endif
                if (grant_i) begin
                    own_i_d = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = S_ISSUE;
                end else if (grant_d) begin
                    own_i_d = 1'b0;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    wmask_d = d_wmask;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (own_i_q && i_kill) kill_d = 1'b1;
                if (!busy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (own_i_q && i_kill) kill_d = 1'b1;
                if (done) begin
                    // A killed fetch still lands here; only its done pulse is dropped.
                    if (own_i_q) i_rdata_d = read_data;
                    else         d_rdata_d = read_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (grant_i)
            starve_cnt_d = 4'd0;
        else if (grant_d && i_req && starve_cnt_q < LIMIT)
            starve_cnt_d = starve_cnt_q + 4'd1;
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            own_i_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            kill_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            own_i_q   <= own_i_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            kill_q    <= kill_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // Every output decodes from registers only.
    assign rw_flag    = (state_q != S_ISSUE) ? 2'b00 :
                        (!own_i_q && we_q)   ? 2'b10 : 2'b01;
    assign addr       = addr_q;
    assign write_data = wdata_q;
    assign write_mask = wmask_q;
    assign i_done     = (state_q == S_RESP) && own_i_q && !kill_q;
    assign d_done     = (state_q == S_RESP) && !own_i_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;

endmodule
